// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the serial Gray-to-binary decoder slice:
//   - gray_state_e      : decoder FSM states (IDLE / CONV / DONE)
//   - GRAY_WIDTH_DEFAULT: default Gray/binary word width
//   - GRAY_MAX_WIDTH    : widest word the popcount helper accepts
//   - gray_popcount()   : number of set bits, used by the adjacency checker
// -----------------------------------------------------------------------------
package gray_pkg;

    localparam int GRAY_WIDTH_DEFAULT = 4;
    localparam int GRAY_MAX_WIDTH     = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } gray_state_e;

    // Counts set bits; narrower words are zero-extended by the caller.
    function automatic int unsigned gray_popcount(input logic [GRAY_MAX_WIDTH-1:0] v);
        int unsigned cnt;
        cnt = 32'd0;
        for (int i = 0; i < GRAY_MAX_WIDTH; i++) begin
            cnt = cnt + {31'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray2bin_serial_if.sv
// -----------------------------------------------------------------------------
// gray2bin_serial_if
// Bundles both handshakes of the serial Gray-to-binary decoder.
//   in_valid / in_ready / gray                   : Gray word input handshake
//   out_valid / out_ready / binary / seq_err     : result output handshake
// Modports:
//   master : the side that supplies Gray words and consumes results
//   slave  : the decoder itself
// -----------------------------------------------------------------------------
interface gray2bin_serial_if
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] binary;
    logic             seq_err;

    modport master (
        output in_valid,
        output gray,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  binary,
        input  seq_err
    );

    modport slave (
        input  in_valid,
        input  gray,
        input  out_ready,
        output in_ready,
        output out_valid,
        output binary,
        output seq_err
    );

endinterface

// File: rtl/gray_adjacency_chk.sv
// -----------------------------------------------------------------------------
// gray_adjacency_chk
// Remembers the previously accepted Gray word and flags a new word that does
// not differ from it in exactly one bit. The first word after reset is never
// flagged because there is nothing to compare against.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   accept       : a new Gray word is being accepted this cycle
//   gray         : the Gray word presented at the accept edge
//   seq_err_next : adjacency verdict for `gray`, meant to be registered by the
//                  parent on the accept edge
// -----------------------------------------------------------------------------
module gray_adjacency_chk
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic [WIDTH-1:0] gray,
    output logic             seq_err_next
);

    logic [WIDTH-1:0]          prev_r;
    logic                      first_r;
    logic [GRAY_MAX_WIDTH-1:0] diff_s;

    // Verdict: any change other than a single-bit step is a violation.
    always_comb begin
        diff_s              = {GRAY_MAX_WIDTH{1'b0}};
        diff_s[WIDTH-1:0]   = gray ^ prev_r;
        seq_err_next        = !first_r && (gray_popcount(diff_s) != 32'd1);
    end

    // History: last accepted word and the "nothing seen yet" flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r  <= {WIDTH{1'b0}};
            first_r <= 1'b1;
        end else if (accept) begin
            prev_r  <= gray;
            first_r <= 1'b0;
        end
    end

endmodule

// File: rtl/gray2bin_serial.sv
// -----------------------------------------------------------------------------
// gray2bin_serial
// Serial Gray-to-binary decoder. Accepts one WIDTH-bit Gray word, resolves one
// binary bit per cycle MSB first (b[i] = b[i+1] ^ g[i]) and returns the result
// over a valid/ready handshake. Latency is WIDTH cycles from accept to
// out_valid; accepts are at least WIDTH+2 cycles apart.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : gray2bin_serial_if.slave
//              in_valid/in_ready/gray                 - Gray word in
//              out_valid/out_ready/binary/seq_err     - result out
// Build option:
//   GRAY2BIN_SEQCHK_EN - when defined, seq_err reports Gray adjacency
//                        violations between consecutive accepted words;
//                        otherwise seq_err is constantly 0.
// All outputs are registered; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module gray2bin_serial
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    gray2bin_serial_if.slave      bus
);

    localparam int                IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(32'd1);
    localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};

    gray_state_e      state_r, state_nx_s;
    logic [IDX_W-1:0] idx_r, idx_nx_s;
    logic [WIDTH-1:0] gray_r, gray_nx_s;
    logic [WIDTH-1:0] res_r, res_nx_s;
    logic [WIDTH-1:0] res_up_s;
    logic [WIDTH-1:0] binary_r, binary_nx_s;
    logic             in_ready_r, in_ready_nx_s;
    logic             out_valid_r, out_valid_nx_s;
    logic             seq_err_r, seq_err_nx_s;
    logic             bit_s;
    logic             accept_s;
    logic             seq_calc_s;

    assign accept_s = (state_r == IDLE) && in_ready_r && bus.in_valid;

`ifdef GRAY2BIN_SEQCHK_EN
    gray_adjacency_chk #(
        .WIDTH (WIDTH)
    ) u_adj_chk (
        .clk          (clk),
        .rst          (rst),
        .accept       (accept_s),
        .gray         (bus.gray),
        .seq_err_next (seq_calc_s)
    );
`else
    assign seq_calc_s = 1'b0;
`endif

    // Next-state and next-output logic for the decoder FSM.
    always_comb begin
        state_nx_s     = state_r;
        idx_nx_s       = idx_r;
        gray_nx_s      = gray_r;
        res_nx_s       = res_r;
        binary_nx_s    = binary_r;
        in_ready_nx_s  = in_ready_r;
        out_valid_nx_s = out_valid_r;
        seq_err_nx_s   = seq_err_r;
        // res_r is cleared at accept, so the shifted-in zero makes the MSB step
        // reduce to b[W-1] = g[W-1] without a special case.
        res_up_s       = res_r >> 1;
        bit_s          = res_up_s[idx_r] ^ gray_r[idx_r];

        case (state_r)
            IDLE: begin
                in_ready_nx_s  = 1'b1;
                out_valid_nx_s = 1'b0;
                if (accept_s) begin
                    state_nx_s    = CONV;
                    gray_nx_s     = bus.gray;
                    idx_nx_s      = IDX_TOP;
                    res_nx_s      = {WIDTH{1'b0}};
                    in_ready_nx_s = 1'b0;
                    seq_err_nx_s  = seq_calc_s;
                end else begin
                    state_nx_s    = IDLE;
                end
            end
            CONV: begin
                in_ready_nx_s   = 1'b0;
                out_valid_nx_s  = 1'b0;
                res_nx_s[idx_r] = bit_s;
                if (idx_r == IDX_ZERO) begin
                    state_nx_s     = DONE;
                    out_valid_nx_s = 1'b1;
                    binary_nx_s    = res_nx_s;
                end else begin
                    idx_nx_s       = idx_r - IDX_ONE;
                end
            end
            DONE: begin
                in_ready_nx_s = 1'b0;
                if (bus.out_ready) begin
                    state_nx_s     = IDLE;
                    out_valid_nx_s = 1'b0;
                    in_ready_nx_s  = 1'b1;
                end else begin
                    out_valid_nx_s = 1'b1;
                end
            end
            default: begin
                state_nx_s     = IDLE;
                in_ready_nx_s  = 1'b1;
                out_valid_nx_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= IDX_ZERO;
            gray_r      <= {WIDTH{1'b0}};
            res_r       <= {WIDTH{1'b0}};
            binary_r    <= {WIDTH{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            seq_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            idx_r       <= idx_nx_s;
            gray_r      <= gray_nx_s;
            res_r       <= res_nx_s;
            binary_r    <= binary_nx_s;
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
            seq_err_r   <= seq_err_nx_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.binary    = binary_r;
    assign bus.seq_err   = seq_err_r;

endmodule

// File: tb/tb_gray2bin_serial.sv
// -----------------------------------------------------------------------------
// tb_gray2bin_serial
// Self-checking bench for gray2bin_serial (WIDTH=4). Expected binary values are
// found by searching for the number whose Gray encoding (n ^ n>>1) equals the
// input word; expected seq_err comes from a first/previous-word history model.
// -----------------------------------------------------------------------------
module tb_gray2bin_serial;

    localparam int WIDTH = 4;

    logic clk;
    logic rst;

    gray2bin_serial_if #(.WIDTH(WIDTH)) bus ();

    gray2bin_serial #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Reference history for the adjacency flag.
    bit               first_m = 1'b1;
    logic [WIDTH-1:0] prev_m  = 4'd0;

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inverse of the encoder: find n with n ^ (n >> 1) == g.
    function automatic logic [WIDTH-1:0] ref_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] n;
        r = 4'd0;
        for (int i = 0; i < (1 << WIDTH); i++) begin
            n = i[WIDTH-1:0];
            if ((n ^ (n >> 1)) == g) r = n;
        end
        return r;
    endfunction

    // Adjacency verdict for an accepted word; advances the history.
    function automatic logic ref_err(input logic [WIDTH-1:0] g);
        logic e;
`ifdef GRAY2BIN_SEQCHK_EN
        e = !first_m && ($countones(g ^ prev_m) != 1);
`else
        e = 1'b0;
`endif
        first_m = 1'b0;
        prev_m  = g;
        return e;
    endfunction

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        first_m = 1'b1;
    endtask

    // One full transaction: accept, wait for result, hold `hold` cycles, handshake.
    task automatic xfer(input logic [WIDTH-1:0] g, input int hold);
        logic [WIDTH-1:0] exp_b;
        logic             exp_e;
        int               lat;
        exp_b = ref_bin(g);
        exp_e = ref_err(g);
        chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        bus.gray     = g;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.gray     = 4'($urandom);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 3 * WIDTH) begin
            chk("in_ready_conv", {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, WIDTH);
        chk("binary", {28'd0, bus.binary}, {28'd0, exp_b});
        chk("seq_err", {31'd0, bus.seq_err}, {31'd0, exp_e});
        chk("in_ready_done", {31'd0, bus.in_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.gray     = 4'($urandom);
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_binary", {28'd0, bus.binary}, {28'd0, exp_b});
            chk("hold_seq_err", {31'd0, bus.seq_err}, {31'd0, exp_e});
            chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        chk("in_ready_back", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] seq [4];
        seq[0] = 4'b0000;
        seq[1] = 4'b0001;
        seq[2] = 4'b0111;
        seq[3] = 4'b0111;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.gray      = 4'd0;
        do_reset();

        // Reset state.
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_binary", {28'd0, bus.binary}, 32'd0);
        chk("rst_seq_err", {31'd0, bus.seq_err}, 32'd0);

        // Directed: 1000 decodes to 1111.
        xfer(4'b1000, 0);
        chk("dir_1000", {28'd0, ref_bin(4'b1000)}, 32'hF);

        // Exhaustive sweep.
        for (int i = 0; i < (1 << WIDTH); i++) begin
            xfer(i[WIDTH-1:0], $urandom_range(0, 2));
        end

        // Backpressure: 0011 -> 0010 held for three cycles.
        xfer(4'b0011, 3);

        // Randomized words with random backpressure.
        for (int i = 0; i < 24; i++) begin
            xfer(4'($urandom), $urandom_range(0, 3));
        end

        // Reset during the second CONV cycle.
        chk("mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.gray     = 4'b0101;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        first_m = 1'b1;
        chk("mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_binary", {28'd0, bus.binary}, 32'd0);
        chk("mid_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        chk("mid_seq_err", {31'd0, bus.seq_err}, 32'd0);
        xfer(4'b1101, 1);

        // Adjacency sequence from a fresh history.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            xfer(seq[i], 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
